// File: rtl/sine_table_loader.sv
// Write-side feeder for the NCO's two sine RAM banks.
// Accepts a valid/ready sample stream and converts it into port-0 write
// strobes for bank 0 (phases 0..2**ADDR_W-1) and bank 1 (the upper half).
// In half-wave mode only the first half-period is streamed and bank 1 is
// filled in the same cycle with the saturated negation, since
// sin(x + pi) = -sin(x).
//
// Handshake: a beat transfers on a rising clk edge when s_valid and s_ready
// are both high. s_ready is decoded from the state register only (high in
// LOAD), never from s_valid. The RAM write for a beat accepted at edge E is
// on the bus during [E, E+1) and is captured by the RAM at E+1.
module sine_table_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              csb00,
    output logic [ADDR_W-1:0] addr00,
    output logic [DATA_W-1:0] din00,
    output logic              csb01,
    output logic [ADDR_W-1:0] addr01,
    output logic [DATA_W-1:0] din01,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;

    // Last beat index: full table, or one bank's worth in half-wave mode.
    localparam logic [CNT_W-1:0]  LAST_FULL = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LAST_HALF = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [DATA_W-1:0] D_MIN     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] D_MAX     = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] D_ONE     = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               csb00_d, csb01_d, done_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  din00_d, din01_d;
    logic [DATA_W-1:0]  neg_data;
    logic               last_beat;

    // Negation that maps the most-negative sample to the most-positive one
    // instead of letting it wrap back onto itself.
    assign neg_data  = (s_data == D_MIN) ? D_MAX : ((~s_data) + D_ONE);
    assign last_beat = mode_q ? (cnt_q == LAST_HALF) : (cnt_q == LAST_FULL);

    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q != IDLE);

    // Next-state and next-output decode; strobes default to inactive so a
    // cycle without a handshake never writes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        csb00_d = 1'b1;
        csb01_d = 1'b1;
        done_d  = 1'b0;
        addr_d  = addr00;
        din00_d = din00;
        din01_d = din01;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    mode_d  = mode;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (s_valid) begin
                    addr_d  = cnt_q[ADDR_W-1:0];
                    din00_d = s_data;
                    din01_d = mode_q ? neg_data : s_data;
                    csb00_d = mode_q ? 1'b0 : cnt_q[ADDR_W];
                    csb01_d = mode_q ? 1'b0 : ~cnt_q[ADDR_W];
                    if (last_beat) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = !abort;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered RAM-side outputs; async reset clears strobes at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            csb00   <= 1'b1;
            csb01   <= 1'b1;
            addr00  <= '0;
            addr01  <= '0;
            din00   <= '0;
            din01   <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            csb00   <= csb00_d;
            csb01   <= csb01_d;
            addr00  <= addr_d;
            addr01  <= addr_d;
            din00   <= din00_d;
            din01   <= din01_d;
            done    <= done_d;
        end
    end

endmodule
